pixel_window_loader: RTL
========================

// Module: pixel_window_loader
// PURPOSE
//  Write side of the 288-bit pixel-window interface (matReaden / dbValue) feeding the FAST9 corner core.
//  Accepts 8-bit pixels serially over a valid/ready handshake and packs 36 pixels into a 6x6 window.
//  Presents the window on dbValue until the core consumes it with matReaden.
//  Two-bank ping-pong buffer: the next window loads while the current one is held.
// PARAMETERS
//  PIX_W    8   bits per pixel
//  WIN_PIX  36  pixels per window; dbValue width = PIX_W*WIN_PIX = 288
// PORTS
//  clk        in   1    system clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  softClr    in   1    synchronous flush: drop partial load and both banks
//  pixIn      in   8    pixel data; raster order, pixel 1 first
//  pixValid   in   1    pixIn valid
//  pixReady   out  1    loader can accept pixIn this cycle
//  winValid   out  1    dbValue holds a complete window
//  matReaden  in   1    core consumes the presented window (read enable)
//  dbValue    out  288  window; pixel k (1..36) at [8k-1:8k-8]
// BEHAVIOUR
//  State: bank0/bank1 (288b each), bankFull[1:0], wrSel, rdSel, pixCnt (6b, 0..35).
//  Reset (async, rst=1): bankFull=0, wrSel=0, rdSel=0, pixCnt=0, banks=0.
//   Outputs in reset: pixReady=1, winValid=0, dbValue=0.
//  pixReady = ~bankFull[wrSel] (combinational from registers; no dependence on pixValid).
//  Accept = pixValid & pixReady. On accept: bank[wrSel][8*pixCnt+:8] <= pixIn; pixCnt++.
//  On accept with pixCnt==35: pixCnt<=0, bankFull[wrSel]<=1, wrSel toggles.
//  winValid = bankFull[rdSel]; dbValue = bank[rdSel] (registered banks, output mux only).
//  Latency: window visible (winValid=1) the cycle after the edge accepting pixel 36.
//  Consume = matReaden & winValid: bankFull[rdSel]<=0, rdSel toggles.
//  matReaden while winValid=0: ignored, no state change.
//  Accept of pixel 36 and consume in the same cycle target different banks. Both take effect.
//   Proof: a read needs bankFull[rdSel]=1; a write needs bankFull[wrSel]=0; hence rdSel!=wrSel.
//  Both banks full: pixReady=0. Stalls until a consume; pixReady=1 the cycle after the consume.
//  pixValid=1 with pixReady=0: pixel not taken. Source holds pixIn until accepted.
//  Bank contents are not cleared on consume. Only bankFull gates use; stale data is harmless.
//  softClr (sync, priority over accept/consume in that cycle):
//   pixCnt=0, bankFull=0, wrSel=rdSel=0. Bank data is retained but invalid.
//  rst asserted mid-load or mid-hold: immediate return to reset values. The partial window is lost.
//  pixCnt never exceeds 35. Wrap happens only via the pixel-36 rule.
// STRUCTURE
//  Shared package (fast9_pkg): PIX_W, WIN_PIX, WIN_W=288 constants; pixel-index width localparam.
//  Sub-module win_bank: one 288-bit bank with byte-write by index (we, idx[5:0], din[7:0]).
//   Instantiated twice, selected by wrSel.
//  Top: pixCnt counter, bankFull/wrSel/rdSel control, and the output mux.
// TESTING
//  1 Reset: rst pulse mid-cycle -> winValid=0, pixReady=1, dbValue=0 immediately, no clk needed.
//  2 Single window: pixels 95,95,95,95,0,0,0,0,95x4,159,159,255,255,159x4,255,255,159,159,
//    95x4,0x4,95x4; matReaden=0 ->
//    winValid=1 one cycle after pixel 36; dbValue[7:0]=95, [39:32]=0, [119:112]=255, [287:280]=95.
//  3 Ping-pong: stream 72 pixels back-to-back, no reads ->
//    pixReady=0 after pixel 72; pulse matReaden ->
//    dbValue switches to window 2; pixReady=1 the next cycle.
//  4 Simultaneous: bank1 has 35 pixels, bank0 full; pixel 36 and matReaden in the same cycle ->
//    rdSel=1, winValid stays 1 with window 2; bankFull=2'b10.
//  5 Handshake: random pixValid gaps; matReaden pulses while winValid=0 ->
//    no extra/lost pixels; scoreboard matches pixel order; spurious reads ignored.
//  6 softClr after 20 pixels with bank0 full -> winValid=0, pixReady=1;
//    next 36 pixels form a window in bank0.

Source files
------------

// File: rtl/fast9_pkg.sv
// Shared constants and control-state type for the FAST9 pixel-window path.
// One window is a 6x6 block of 8-bit pixels packed pixel 1 at the LSB.
package fast9_pkg;

  localparam int PIX_W     = 8;
  localparam int WIN_PIX   = 36;
  localparam int WIN_W     = PIX_W * WIN_PIX;
  localparam int PIX_IDX_W = $clog2(WIN_PIX);

  localparam logic [PIX_IDX_W-1:0] LAST_IDX = PIX_IDX_W'(WIN_PIX - 1);

  typedef struct packed {
    logic [1:0]           bankFull;
    logic                 wrSel;
    logic                 rdSel;
    logic [PIX_IDX_W-1:0] pixCnt;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '0;

  // Pixel index advance; the only wrap point is the last pixel of a window.
  function automatic logic [PIX_IDX_W-1:0] nextIdx(input logic [PIX_IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/win_bank.sv
// One window buffer with byte write by pixel index; contents visible one cycle after the write.
// No flow control of its own: the writer guarantees we is only raised for a free bank.
module win_bank
  import fast9_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [PIX_IDX_W-1:0] idx,
  input  logic [PIX_W-1:0]     din,
  output logic [WIN_W-1:0]     dout
);

  logic [WIN_W-1:0] data;

  // Per-slot compare instead of a variable part-select keeps the write decode flat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (we) begin
      for (int k = 0; k < WIN_PIX; k++) begin
        if (idx == PIX_IDX_W'(k)) begin
          data[k*PIX_W +: PIX_W] <= din;
        end
      end
    end
  end

  assign dout = data;

endmodule

// File: rtl/pixel_window_loader.sv
// Packs serial pixels into 288-bit windows in a two-bank ping-pong buffer for the FAST9 core.
// Window valid one cycle after pixel 36 is taken; pixReady drops only while both banks are held.
module pixel_window_loader
  import fast9_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             softClr,
  input  logic [PIX_W-1:0] pixIn,
  input  logic             pixValid,
  output logic             pixReady,
  output logic             winValid,
  input  logic             matReaden,
  output logic [WIN_W-1:0] dbValue
);

  ctrl_t            ctrlQ;
  ctrl_t            ctrlD;
  logic             accept;
  logic             consume;
  logic             lastPix;
  logic [1:0]       bankWe;
  logic [WIN_W-1:0] bankDat [2];

  assign pixReady = ~ctrlQ.bankFull[ctrlQ.wrSel];
  assign winValid = ctrlQ.bankFull[ctrlQ.rdSel];
  assign dbValue  = ctrlQ.rdSel ? bankDat[1] : bankDat[0];

  assign accept  = pixValid & pixReady;
  assign consume = matReaden & winValid;
  assign lastPix = (ctrlQ.pixCnt == LAST_IDX);

  // softClr also blocks the write so a flushed cycle leaves no trace in either bank.
  assign bankWe[0] = accept & ~softClr & ~ctrlQ.wrSel;
  assign bankWe[1] = accept & ~softClr &  ctrlQ.wrSel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrlQ <= CTRL_RESET;
    end else begin
      ctrlQ <= ctrlD;
    end
  end

  // A completing write and a consume can share a cycle: the write targets a free bank and
  // the read a full one, so wrSel != rdSel and both bankFull updates land on different bits.
  always_comb begin
    ctrlD = ctrlQ;
    if (softClr) begin
      ctrlD = CTRL_RESET;
    end else begin
      if (accept) begin
        ctrlD.pixCnt = nextIdx(ctrlQ.pixCnt);
        if (lastPix) begin
          ctrlD.bankFull[ctrlQ.wrSel] = 1'b1;
          ctrlD.wrSel                 = ~ctrlQ.wrSel;
        end
      end
      if (consume) begin
        ctrlD.bankFull[ctrlQ.rdSel] = 1'b0;
        ctrlD.rdSel                 = ~ctrlQ.rdSel;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : gBank
    win_bank uBank (
      .clk  (clk),
      .rst  (rst),
      .we   (bankWe[b]),
      .idx  (ctrlQ.pixCnt),
      .din  (pixIn),
      .dout (bankDat[b])
    );
  end

endmodule
